// File: rtl/moore_fsm.sv
// -----------------------------------------------------------------------------
// moore_fsm
//   Moore-type serial detector for the bit pattern "101" on din.  The detect
//   flag y is a registered decode of the next state, so it always equals
//   (present state == S3) and has no combinational path from din.  A
//   saturating counter records how many times the detect state was entered.
//
// Parameters
//   OVERLAP : 1 = the trailing "1" of a match may start the next pattern,
//             0 = matches never share bits.
//   CNT_W   : width of match_cnt.
//
// Ports
//   clk       in   system clock, rising edge active
//   rst       in   asynchronous reset, active low
//   din       in   serial data bit, sampled on the rising edge of clk
//   y         out  detect flag, high while in S3
//   PS_out    out  present-state register (S0=00, S1=01, S2=10, S3=11)
//   match_cnt out  number of S3 entries since reset, saturating at all-ones
// -----------------------------------------------------------------------------
module moore_fsm #(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             y,
    output logic [1:0]       PS_out,
    output logic [CNT_W-1:0] match_cnt
);

    typedef enum logic [1:0] {
        S0 = 2'b00,  // idle, no prefix seen
        S1 = 2'b01,  // "1" seen
        S2 = 2'b10,  // "10" seen
        S3 = 2'b11   // "101" seen, detect
    } state_t;

    state_t ps;
    state_t ns;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Next-state decode.  if/else (not ?:) so an unknown din falls to the
    // else branch and keeps the state register free of X in simulation.
    always_comb begin
        ns = S0;
        case (ps)
            S0: begin
                if (din) ns = S1;
                else     ns = S0;
            end
            S1: begin
                if (din) ns = S1;
                else     ns = S2;
            end
            S2: begin
                if (din) ns = S3;
                else     ns = S0;
            end
            S3: begin
                if (din)              ns = S1;
                else if (OVERLAP != 0) ns = S2;  // reuse the trailing "1"
                else                  ns = S0;
            end
            default: ns = S0;
        endcase
    end

    // y is registered from ns, which keeps it identical to (ps == S3).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps        <= S0;
            y         <= 1'b0;
            match_cnt <= '0;
        end else begin
            ps <= ns;
            y  <= (ns == S3);
            if (ns == S3) begin
                match_cnt <= sat_inc(match_cnt);
            end
        end
    end

    assign PS_out = ps;

endmodule

// File: tb/tb_moore_fsm.sv
module tb_moore_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;

    // Instance 0: overlapping, 8-bit count; 1: non-overlapping; 2: 2-bit count.
    logic       y0, y1, y2;
    logic [1:0] ps0, ps1, ps2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    moore_fsm #(.OVERLAP(1), .CNT_W(8)) dut_ov (
        .clk(clk), .rst(rst), .din(din), .y(y0), .PS_out(ps0), .match_cnt(c0));
    moore_fsm #(.OVERLAP(0), .CNT_W(8)) dut_no (
        .clk(clk), .rst(rst), .din(din), .y(y1), .PS_out(ps1), .match_cnt(c1));
    moore_fsm #(.OVERLAP(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .din(din), .y(y2), .PS_out(ps2), .match_cnt(c2));

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // ---------------- behavioural reference model ----------------
    // Detection is defined on the stream of bits that are still eligible to
    // form a pattern: everything since reset (overlap), or everything since
    // the end of the last match (non-overlap).  The exported state is the
    // longest suffix of that stream that is a prefix of "101", or 3 when the
    // last three eligible bits are exactly "101".
    int          m_ov  [3] = '{1, 0, 1};
    int          m_max [3] = '{255, 255, 3};
    int          m_n   [3];      // eligible bit count, capped at 3
    logic [2:0]  m_h   [3];      // last eligible bits, newest in bit 0
    int          m_st  [3];
    int          m_cnt [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_n[i] = 0; m_h[i] = 3'b000; m_st[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_step(input logic b);
        for (int i = 0; i < 3; i++) begin
            m_h[i] = {m_h[i][1:0], b};
            m_n[i] = (m_n[i] < 3) ? m_n[i] + 1 : 3;
            if (m_n[i] >= 3 && m_h[i] == 3'b101) begin
                m_st[i]  = 3;
                m_cnt[i] = (m_cnt[i] < m_max[i]) ? m_cnt[i] + 1 : m_max[i];
                if (m_ov[i] == 0) m_n[i] = 0;
            end else if (m_n[i] >= 2 && m_h[i][1:0] == 2'b10) begin
                m_st[i] = 2;
            end else if (m_n[i] >= 1 && m_h[i][0]) begin
                m_st[i] = 1;
            end else begin
                m_st[i] = 0;
            end
        end
    endtask

    initial model_reset();

    // Compare process: every clock edge and every reset assertion.
    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step(din);
        #1;
        chk("ov_ps",   {30'd0, ps0}, m_st[0]);
        chk("ov_y",    {31'd0, y0},  (m_st[0] == 3) ? 1 : 0);
        chk("ov_cnt",  {24'd0, c0},  m_cnt[0]);
        chk("no_ps",   {30'd0, ps1}, m_st[1]);
        chk("no_y",    {31'd0, y1},  (m_st[1] == 3) ? 1 : 0);
        chk("no_cnt",  {24'd0, c1},  m_cnt[1]);
        chk("sat_ps",  {30'd0, ps2}, m_st[2]);
        chk("sat_y",   {31'd0, y2},  (m_st[2] == 3) ? 1 : 0);
        chk("sat_cnt", {30'd0, c2},  m_cnt[2]);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic b);
        @(negedge clk);
        din = b;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        din = 1'b1;
        repeat (2) begin
            @(negedge clk);
            din = ~din;
        end
        rst = 1'b1;
        din = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("lit_async_reset_ps", {30'd0, ps0}, 0);
        @(negedge clk);
        din = 1'b1;
        @(negedge clk);
        din = 1'b0;
        rst = 1'b1;

        // Reset release: stays idle until a 1 is sampled.
        step(1'b0);
        chk("lit_idle_after_rst", {30'd0, ps0}, 0);

        // Basic "101".
        do_reset();
        step(1'b1); chk("lit_101_e1_ps", {30'd0, ps0}, 1);
        step(1'b0); chk("lit_101_e2_ps", {30'd0, ps0}, 2);
        step(1'b1); chk("lit_101_e3_ps", {30'd0, ps0}, 3);
        chk("lit_101_y", {31'd0, y0}, 1);
        chk("lit_101_cnt", {24'd0, c0}, 1);
        step(1'b1); chk("lit_101_y_drop", {31'd0, y0}, 0);

        // "10101": overlap vs non-overlap.
        do_reset();
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        chk("lit_ov_e4_ps", {30'd0, ps0}, 2);
        chk("lit_no_e4_ps", {30'd0, ps1}, 0);
        step(1'b1);
        chk("lit_ov_cnt2", {24'd0, c0}, 2);
        chk("lit_ov_y_e5", {31'd0, y0}, 1);
        chk("lit_no_cnt1", {24'd0, c1}, 1);
        chk("lit_no_y_e5", {31'd0, y1}, 0);

        // "101101".
        do_reset();
        step(1'b1); step(1'b0); step(1'b1); step(1'b1);
        chk("lit_mix_e4_ps", {30'd0, ps0}, 1);
        step(1'b0); step(1'b1);
        chk("lit_mix_y_e6", {31'd0, y0}, 1);
        chk("lit_mix_cnt", {24'd0, c0}, 2);

        // "11001": never detects.
        do_reset();
        step(1'b1); step(1'b1); step(1'b0); step(1'b0); step(1'b1);
        chk("lit_none_cnt", {24'd0, c0}, 0);

        // Asynchronous reset while in S2, between clock edges.
        do_reset();
        step(1'b1); step(1'b0);
        chk("lit_pre_async_ps", {30'd0, ps0}, 2);
        rst = 1'b0;
        #1;
        chk("lit_async_mid_ps", {30'd0, ps0}, 0);
        chk("lit_async_mid_no", {30'd0, ps1}, 0);
        @(negedge clk);
        rst = 1'b1;

        // Saturation: five overlapping matches on a 2-bit counter.
        do_reset();
        step(1'b1);
        repeat (5) begin
            step(1'b0); step(1'b1);
        end
        chk("lit_sat_cnt", {30'd0, c2}, 3);
        chk("lit_sat_wide_cnt", {24'd0, c0}, 5);

        // Random stream with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else step(1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/moore_fsm.md
Name: moore_fsm

Overview:
- Moore-type serial sequence detector for the bit pattern "101" on a single-bit input stream `din`, sampled once per clock.
- Output `y` is decoded purely from the present state. It asserts for exactly one cycle per detected pattern.
- The present-state encoding is exported on `PS_out` for debug and observation.
- A saturating match counter is provided for status logging. The block sits on a serial data path as a pattern flag generator.

Parameters:
- OVERLAP, 1, 1 = overlapping detection (the trailing "1" of a match can start the next pattern); 0 = non-overlapping.
- CNT_W, 8, width of the saturating match counter `match_cnt`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately; rst=1 runs).
- din  input  1  serial data bit, sampled on the rising edge of clk.
- y  output  1  detect flag = 1 while the present state is S3; Moore output, no combinational path from din.
- PS_out  output  2  present-state register value (encoding below).
- match_cnt  output  CNT_W  number of S3 entries since reset, saturating at all-ones.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports `clk`, `rst`).
- State encoding, 2-bit register:
  - S0=2'b00: idle, no prefix seen.
  - S1=2'b01: "1" seen.
  - S2=2'b10: "10" seen.
  - S3=2'b11: "101" seen, detect state.
- Reset (rst=0, asynchronous, held as long as low):
  - PS=S0, so PS_out=2'b00.
  - y=0.
  - match_cnt=0.
- Reset mid-operation: any partial prefix is discarded immediately.
- Leaving reset: the first active edge after rst rises samples din normally.
- Transitions on each rising clk edge when rst=1:
  - S0: din=1 -> S1; din=0 -> S0.
  - S1: din=1 -> S1; din=0 -> S2.
  - S2: din=1 -> S3; din=0 -> S0.
  - S3, OVERLAP=1: din=1 -> S1; din=0 -> S2.
  - S3, OVERLAP=0: din=1 -> S1; din=0 -> S0.
- Outputs:
  - y = (PS == S3), decoded from the state register only. Glitch-free relative to din changes.
  - Latency: y rises in the cycle immediately after the edge that samples the final "1" of the pattern. It stays high for one cycle, or longer only if consecutive matches occur (not possible for "101"; see the S3 transitions).
  - PS_out = PS register, updated on the same edge.
- Counter:
  - match_cnt increments by 1 on every edge whose next state is S3.
  - Saturates at 2^CNT_W-1 and never wraps.
- Illegal states: none exist with 2-bit encoding. The default branch still returns S0 for robustness.
- No X propagation: an X on din in S0 must not corrupt PS in simulation; treat as 0 via a default branch.

Test Plan:
- Reset: hold rst=0 for 2 cycles with din toggling -> PS_out=00, y=0, match_cnt=0 throughout; deassert rst -> PS_out stays 00 until din=1 is sampled.
- Basic detect: din 1,0,1 on successive edges -> PS_out 01,10,11; y=1 only in the cycle after the third edge; match_cnt=1.
- Overlap (OVERLAP=1): din 1,0,1,0,1 -> y pulses twice (after edges 3 and 5); match_cnt=2; PS_out after edge 4 = 10.
- Non-overlap (OVERLAP=0): din 1,0,1,0,1 -> single y pulse after edge 3; PS_out after edge 4 = 00; match_cnt=1.
- Mixed stream: din 1,0,1,1,0,1 -> y pulses after edges 3 and 6; PS_out after edge 4 = 01; din 1,1,0,0,1 -> y never asserts.
- Async reset mid-pattern and saturation: drive rst=0 between clock edges while PS=S2 -> PS_out=00 immediately, with no clock needed. With CNT_W=2, run 5 matches -> match_cnt stops at 3.
